// File: rtl/encoder_layer_1_attention_self_value_bias_sink.sv
// ---------------------------------------------------------------------------
// encoder_layer_1_attention_self_value_bias_sink
//
// Loads the layer-1 attention value-bias tensor from a valid/ready stream into
// an internal RAM. Once the tensor is complete, the RAM can be read through the
// same 2-cycle address0/ce0/q0 port that the parameter ROM provides.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous, active-low reset
//   data_in        one beat of PAR_0*PAR_1 elements
//   data_in_valid  beat present
//   data_in_ready  beat accepted this cycle (combinational)
//   clear          synchronous restart of the fill
//   address0       read address (>= IN_DEPTH reads as zero)
//   ce0            read pipeline enable for both read stages
//   q0             read data, 2-cycle latency
//   beat_count     beats written since the last reset or clear
//   loaded         full tensor present in RAM
//   tensor_done    one-cycle pulse after the last beat is written
// ---------------------------------------------------------------------------
module encoder_layer_1_attention_self_value_bias_sink #(
    parameter int unsigned VALUE_BIAS_TENSOR_SIZE_DIM_0 = 32,
    parameter int unsigned VALUE_BIAS_TENSOR_SIZE_DIM_1 = 1,
    parameter int unsigned VALUE_BIAS_PRECISION_0       = 16,
    parameter int unsigned VALUE_BIAS_PRECISION_1       = 3,
    parameter int unsigned VALUE_BIAS_PARALLELISM_DIM_0 = 1,
    parameter int unsigned VALUE_BIAS_PARALLELISM_DIM_1 = 1,
    parameter int unsigned IN_DEPTH   = VALUE_BIAS_TENSOR_SIZE_DIM_0 / VALUE_BIAS_PARALLELISM_DIM_0,
    parameter int unsigned ADDR_WIDTH = $clog2(IN_DEPTH) + 1,
    parameter int unsigned BEAT_WIDTH = VALUE_BIAS_PRECISION_0 * VALUE_BIAS_PARALLELISM_DIM_0
                                        * VALUE_BIAS_PARALLELISM_DIM_1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [VALUE_BIAS_PRECISION_0-1:0] data_in [VALUE_BIAS_PARALLELISM_DIM_0*VALUE_BIAS_PARALLELISM_DIM_1],
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    input  logic                              clear,
    input  logic [ADDR_WIDTH-1:0]             address0,
    input  logic                              ce0,
    output logic [BEAT_WIDTH-1:0]             q0,
    output logic [ADDR_WIDTH-1:0]             beat_count,
    output logic                              loaded,
    output logic                              tensor_done
);

    localparam int unsigned NUM_ELEM  = VALUE_BIAS_PARALLELISM_DIM_0 * VALUE_BIAS_PARALLELISM_DIM_1;
    localparam int unsigned MEM_IDX_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    // Reject parameter sets that cannot describe a loadable tensor.
    if (VALUE_BIAS_TENSOR_SIZE_DIM_1 == 0 || IN_DEPTH == 0
        || VALUE_BIAS_PRECISION_1 > VALUE_BIAS_PRECISION_0) begin : g_bad_params
        $error("value bias sink: inconsistent tensor parameters");
    end

    typedef enum logic {
        FILL   = 1'b0,
        LOADED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic                    loaded_q, loaded_d;
    logic                    tensor_done_q, tensor_done_d;
    logic [BEAT_WIDTH-1:0]   t0_q, t0_d;
    logic [BEAT_WIDTH-1:0]   q0_q, q0_d;

    logic [BEAT_WIDTH-1:0]   mem [IN_DEPTH];
    logic [BEAT_WIDTH-1:0]   wr_data_c;
    logic                    wr_en_c;
    logic                    rd_in_range_c;

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign data_in_ready = rst && (state_q == FILL) && !clear;
    assign wr_en_c       = data_in_valid && data_in_ready;

    // Element j lands in word bits [PRECISION_0*j +: PRECISION_0].
    always_comb begin
        wr_data_c = '0;
        for (int unsigned j = 0; j < NUM_ELEM; j++) begin
            wr_data_c[VALUE_BIAS_PRECISION_0*j +: VALUE_BIAS_PRECISION_0] = data_in[j];
        end
    end

    // Fill control: clear wins over any same-cycle beat.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        loaded_d      = loaded_q;
        tensor_done_d = 1'b0;
        if (clear) begin
            state_d  = FILL;
            wr_ptr_d = '0;
            loaded_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (wr_en_c) begin
                        // Pointer runs one past the last address so beat_count reads IN_DEPTH.
                        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                        if (wr_ptr_q == ADDR_WIDTH'(IN_DEPTH - 1)) begin
                            state_d       = LOADED;
                            loaded_d      = 1'b1;
                            tensor_done_d = 1'b1;
                        end
                    end
                end
                LOADED: begin
                    loaded_d = 1'b1;
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // Two-stage read pipeline; mem is read before this edge's write lands.
    always_comb begin
        rd_in_range_c = (address0 < ADDR_WIDTH'(IN_DEPTH));
        t0_d          = t0_q;
        q0_d          = q0_q;
        if (ce0) begin
            q0_d = t0_q;
            t0_d = rd_in_range_c ? mem[address0[MEM_IDX_W-1:0]] : '0;
        end
    end

    // Control and read-pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FILL;
            wr_ptr_q      <= '0;
            loaded_q      <= 1'b0;
            tensor_done_q <= 1'b0;
            t0_q          <= '0;
            q0_q          <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            loaded_q      <= loaded_d;
            tensor_done_q <= tensor_done_d;
            t0_q          <= t0_d;
            q0_q          <= q0_d;
        end
    end

    // Bias storage; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q[MEM_IDX_W-1:0]] <= wr_data_c;
        end
    end

    assign q0          = q0_q;
    assign beat_count  = wr_ptr_q;
    assign loaded      = loaded_q;
    assign tensor_done = tensor_done_q;

endmodule

// File: tb/tb_encoder_layer_1_attention_self_value_bias_sink.sv
// Bench for the value-bias sink: a behavioural model of the loader checked
// against the DUT on every falling edge, plus literal expectations per scenario.
module tb_encoder_layer_1_attention_self_value_bias_sink;

    localparam int DEPTH = 32;

    logic        clk;
    logic        rst;
    logic [15:0] data_in [1];
    logic        data_in_valid;
    logic        data_in_ready;
    logic        clear;
    logic [5:0]  address0;
    logic        ce0;
    logic [15:0] q0;
    logic [5:0]  beat_count;
    logic        loaded;
    logic        tensor_done;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    // Behavioural model state
    int          m_count  = 0;
    logic        m_loaded = 1'b0;
    logic        m_done   = 1'b0;
    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_t0 = '0;
    logic [15:0] m_q0 = '0;

    encoder_layer_1_attention_self_value_bias_sink dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .clear        (clear),
        .address0     (address0),
        .ce0          (ce0),
        .q0           (q0),
        .beat_count   (beat_count),
        .loaded       (loaded),
        .tensor_done  (tensor_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return rst && !m_loaded && !clear;
    endfunction

    // Model: accept while not full and not clearing; read old word before write.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_count  = 0;
            m_loaded = 1'b0;
            m_done   = 1'b0;
            m_t0     = '0;
            m_q0     = '0;
        end else begin
            logic hs;
            hs = data_in_valid && m_ready();
            if (ce0) begin
                m_q0 = m_t0;
                m_t0 = (address0 < 6'(DEPTH)) ? m_mem[address0[4:0]] : 16'h0;
            end
            m_done = 1'b0;
            if (clear) begin
                m_count  = 0;
                m_loaded = 1'b0;
            end else if (hs) begin
                m_mem[m_count] = data_in[0];
                m_count++;
                if (m_count == DEPTH) begin
                    m_loaded = 1'b1;
                    m_done   = 1'b1;
                end
            end
        end
    end

    // Compare process on every falling edge.
    always @(negedge clk) begin
        chk("ready",       32'(data_in_ready), 32'(m_ready()));
        chk("beat_count",  32'(beat_count),    32'(m_count));
        chk("loaded",      32'(loaded),        32'(m_loaded));
        chk("tensor_done", 32'(tensor_done),   32'(m_done));
        chk("q0",          32'(q0),            32'(m_q0));
        if (tensor_done === 1'b1) done_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            data_in_valid = 1'b1;
            data_in[0]    = base + 16'(i);
            step();
        end
        data_in_valid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [15:0] exp, input string name);
        address0 = a;
        ce0      = 1'b1;
        step();
        step();
        chk(name, 32'(q0), 32'(exp));
        ce0 = 1'b0;
    endtask

    initial begin
        int pulses0;
        int cyc;
        rst           = 1'b1;
        data_in[0]    = '0;
        data_in_valid = 1'b0;
        clear         = 1'b0;
        address0      = '0;
        ce0           = 1'b0;
        #1 rst = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_ready",  32'(data_in_ready), 32'd0);
        chk("rst_q0",     32'(q0),            32'd0);
        chk("rst_loaded", 32'(loaded),        32'd0);
        chk("rst_count",  32'(beat_count),    32'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 32'(data_in_ready), 32'd1);

        // Scenario 1: full back-to-back load
        pulses0 = done_pulses;
        stream(16'h0001, DEPTH);
        chk("s1_done",   32'(tensor_done), 32'd1);
        chk("s1_loaded", 32'(loaded),      32'd1);
        chk("s1_count",  32'(beat_count),  32'd32);
        step();
        chk("s1_done_low", 32'(tensor_done), 32'd0);
        chk("s1_pulses", 32'(done_pulses - pulses0), 32'd1);
        rd(6'd5,  16'h0006, "s1_rd5");
        rd(6'd31, 16'h0020, "s1_rd31");

        // Scenario 2: refill with ~50% valid bubbles
        clear = 1'b1;
        step();
        clear = 1'b0;
        pulses0 = done_pulses;
        cyc = 0;
        while (!m_loaded && cyc < 1000) begin
            data_in_valid = 1'($urandom_range(0, 1));
            data_in[0]    = 16'(m_count + 1);
            step();
            cyc++;
        end
        data_in_valid = 1'b0;
        if (cyc >= 1000) chk("s2_timeout", 32'(cyc), 32'd0);
        step();
        chk("s2_pulses", 32'(done_pulses - pulses0), 32'd1);
        for (int i = 0; i < DEPTH; i++) rd(6'(i), 16'(i + 1), "s2_rd");

        // Scenario 3: loaded sink stalls upstream
        data_in_valid = 1'b1;
        data_in[0]    = 16'hFFFF;
        for (int i = 0; i < 6; i++) step();
        chk("s3_ready", 32'(data_in_ready), 32'd0);
        chk("s3_count", 32'(beat_count),    32'd32);
        rd(6'd0, 16'h0001, "s3_rd0");

        // Scenario 4: clear while loaded (valid still high), then new tensor
        clear = 1'b1;
        #1;
        chk("s4_ready_clear", 32'(data_in_ready), 32'd0);
        step();
        clear = 1'b0;
        data_in_valid = 1'b0;
        chk("s4_loaded", 32'(loaded),     32'd0);
        chk("s4_count",  32'(beat_count), 32'd0);
        stream(16'h1000, DEPTH);
        chk("s4_loaded2", 32'(loaded), 32'd1);
        for (int i = 0; i < DEPTH; i++) rd(6'(i), 16'h1000 + 16'(i), "s4_rd");

        // Scenario 5: clear collides with beat 10 mid-fill
        clear = 1'b1;
        step();
        clear = 1'b0;
        stream(16'h2000, 10);
        clear         = 1'b1;
        data_in_valid = 1'b1;
        data_in[0]    = 16'hAAAA;
        #1;
        chk("s5_ready", 32'(data_in_ready), 32'd0);
        step();
        clear         = 1'b0;
        data_in_valid = 1'b0;
        chk("s5_count", 32'(beat_count), 32'd0);
        stream(16'h3000, 1);
        chk("s5_count1", 32'(beat_count), 32'd1);
        rd(6'd0,  16'h3000, "s5_rd0");
        rd(6'd10, 16'h100A, "s5_rd10");

        // Scenario 6: asynchronous reset mid-fill, refill, hold and out-of-range
        stream(16'h4000, 5);
        data_in_valid = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("s6_q0",     32'(q0),            32'd0);
        chk("s6_loaded", 32'(loaded),        32'd0);
        chk("s6_ready",  32'(data_in_ready), 32'd0);
        chk("s6_count",  32'(beat_count),    32'd0);
        data_in_valid = 1'b0;
        step();
        rst = 1'b1;
        stream(16'h5000, DEPTH);
        chk("s6_loaded2", 32'(loaded), 32'd1);
        rd(6'd7, 16'h5007, "s6_rd7");
        address0 = 6'd3;
        for (int i = 0; i < 4; i++) step();
        chk("s6_hold", 32'(q0), 32'h5007);
        rd(6'd40, 16'h0000, "s6_rd40");
        rd(6'd0,  16'h5000, "s6_rd0");

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder_layer_1_attention_self_value_bias_sink.md
# encoder_layer_1_attention_self_value_bias_sink

Stream-to-memory loader for the layer-1 attention value bias. It accepts the bias tensor as a valid/ready stream of parallel beats and writes each beat into an internal RAM. It raises a loaded flag once the full tensor has been captured. It exposes the same 2-cycle `address0/ce0/q0` read port as the parameter ROM, so a downstream parameter source can read from it unchanged.

## Interface
Parameters:
- VALUE_BIAS_TENSOR_SIZE_DIM_0, 32, elements per tensor row
- VALUE_BIAS_TENSOR_SIZE_DIM_1, 1, tensor rows (informational; one row is loaded)
- VALUE_BIAS_PRECISION_0, 16, element width in bits
- VALUE_BIAS_PRECISION_1, 3, fractional bits (informational only, no arithmetic)
- VALUE_BIAS_PARALLELISM_DIM_0, 1, elements per beat along dim 0
- VALUE_BIAS_PARALLELISM_DIM_1, 1, elements per beat along dim 1
- IN_DEPTH, TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0, beats per tensor; also RAM depth
- ADDR_WIDTH, $clog2(IN_DEPTH)+1, width of the write pointer and read address
- BEAT_WIDTH, PRECISION_0 * PARALLELISM_DIM_0 * PARALLELISM_DIM_1, width of one RAM word

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- data_in  in  [PRECISION_0-1:0] x PAR_0*PAR_1 unpacked array  one beat of elements
- data_in_valid  in  1  beat present
- data_in_ready  out  1  sink will accept the beat this cycle
- clear  in  1  synchronous one-cycle request to restart filling
- address0  in  ADDR_WIDTH  read address
- ce0  in  1  read-pipeline enable
- q0  out  BEAT_WIDTH  read data, 2-cycle latency
- beat_count  out  ADDR_WIDTH  beats written since the last reset or clear
- loaded  out  1  full tensor present in RAM
- tensor_done  out  1  one-cycle pulse when the last beat is written

## Operation
- Packing: element j of data_in occupies RAM word bits [PRECISION_0*j +: PRECISION_0]. This matches the source-side unpacking.
- States: FILL and LOADED. Reset enters FILL.
- FILL:
  - data_in_ready = !clear.
  - A handshake (valid && ready) writes RAM[wr_ptr] and increments wr_ptr.
  - A handshake with wr_ptr == IN_DEPTH-1 transitions to LOADED and pulses tensor_done.
- LOADED:
  - data_in_ready = 0. Further beats stall upstream and are never written.
  - loaded = 1.
- clear:
  - In either state, the next state is FILL, with wr_ptr = 0, loaded = 0 and tensor_done = 0.
  - clear has priority over a same-cycle beat: ready is low, so no write occurs.
  - RAM contents are retained but are stale until overwritten.
- beat_count = wr_ptr. Range is 0..IN_DEPTH-1 in FILL. It holds IN_DEPTH in LOADED (pointer increments past the last address, no wrap).
- Read port:
  - Two registered stages, t0 <= RAM[address0] then q0 <= t0. Both stages are gated by ce0.
  - ce0 = 0 freezes q0.
  - Reads are legal in any state.
  - address0 >= IN_DEPTH loads 0 into t0.
- Same-cycle read and write to the same address returns the old word (read-before-write).
- The value is a raw bit copy: no sign or fixed-point handling.

## Timing
- Reset (rst = 0, asynchronous) forces immediately:
  - state = FILL, wr_ptr = 0
  - loaded = 0, tensor_done = 0
  - t0 = 0, q0 = 0
  - data_in_ready = 0 while rst is low
- The RAM is not reset.
- First acceptance: ready rises combinationally after rst deasserts. The first handshake can occur at the first rising edge with rst high.
- Throughput: 1 beat/cycle. Full load takes IN_DEPTH handshake cycles.
- tensor_done and loaded are registered. They rise in the cycle after the final handshake edge. tensor_done is high for exactly one cycle.
- Write-to-read: a beat written at edge N is visible at address0 sampled at edge N+1. The data appears on q0 after edge N+2.
- Read latency: address0 sampled at edge N (ce0 = 1 at edges N and N+1) produces q0 valid after edge N+1.
- clear asserted in cycle C: ready is low in C. At edge C+1, loaded = 0 and beat_count = 0.
- Reset mid-fill: partial contents remain in RAM and beat_count returns to 0. Refill starts at address 0.

## Test plan
- Reset, then stream 32 beats of 0x0001..0x0020 with valid held high → ready stays 1 for 32 cycles. tensor_done pulses once the cycle after beat 32 and loaded = 1. Read address 5 gives q0 = 0x0006 after 2 edges; address 31 gives 0x0020.
- Random valid bubbles, about 50% duty → beat_count advances only on handshakes. Final RAM contents are identical to the first scenario; tensor_done occurs exactly once.
- After loaded, hold valid high with 0xFFFF → ready = 0 indefinitely. A read of address 0 still returns 0x0001.
- clear while loaded, then stream 0x1000+i → loaded falls the next cycle and beat_count = 0. Readback gives 0x1000..0x101F.
- During FILL at beat 10, assert clear in the same cycle as valid with 0xAAAA → no write. beat_count = 0 the next cycle, and the next beat lands at address 0.
- Assert rst low between edges mid-fill → q0, loaded and ready go 0 immediately. With ce0 = 0 after refill, q0 holds its last value. Out-of-range address 40 returns 0.
